// File: rtl/run_control_unit.sv
// Run controller for a small core: holds the core in reset, lets it run until
// halt, timeout or abort, then freezes it and reports how the run ended.
module run_control_unit #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             halt,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic [PC_W-1:0]  core_pc,
  output logic             core_rst_n,
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count,
  output logic [PC_W-1:0]  last_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             halted_q, halted_d;
  logic             to_q, to_d;
  logic             done_q, done_d;
  logic             rstn_q, rstn_d;
  logic             run_en_q, run_en_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             tmo_hit;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign tmo_hit = (tmo_q != '0) && (cnt_q == tmo_q - CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    to_d     = to_q;
    done_d   = 1'b0;

    // Abort wins over everything; in IDLE it simply suppresses a start.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_RESET;
            hold_d   = '0;
            tmo_d    = timeout_cycles;
            cnt_d    = '0;
            halted_d = 1'b0;
            to_d     = 1'b0;
          end
        end
        S_RESET: begin
          if (hold_q == 8'(RST_HOLD - 1)) begin
            state_d = S_RUN;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        S_RUN: begin
          if (halt) begin
            state_d  = S_DONE;
            halted_d = 1'b1;
            cnt_d    = cnt_inc;
            pc_d     = core_pc;
            done_d   = 1'b1;
          end else if (tmo_hit) begin
            state_d = S_DONE;
            to_d    = 1'b1;
            cnt_d   = tmo_q;
            pc_d    = core_pc;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Output registers follow the next state so they line up with it.
    rstn_d   = (state_d == S_RUN) || (state_d == S_DONE);
    run_en_d = (state_d == S_RUN);
    busy_d   = (state_d == S_RESET) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      pc_q     <= '0;
      halted_q <= 1'b0;
      to_q     <= 1'b0;
      done_q   <= 1'b0;
      rstn_q   <= 1'b0;
      run_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      to_q     <= to_d;
      done_q   <= done_d;
      rstn_q   <= rstn_d;
      run_en_q <= run_en_d;
      busy_q   <= busy_d;
    end
  end

  assign core_rst_n  = rstn_q;
  assign run_en      = run_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halted      = halted_q;
  assign timed_out   = to_q;
  assign cycle_count = cnt_q;
  assign last_pc     = pc_q;

endmodule

// File: tb/tb_run_control_unit.sv
// Bench for run_control_unit: directed and random runs, expected run outcomes
// queued at start and matched whenever busy drops.
module tb_run_control_unit;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PC_W     = 16;
  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned NEVER    = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             halt = 1'b0;
  logic [CNT_W-1:0] timeout_cycles = '0;
  logic [PC_W-1:0]  core_pc = '0;
  logic             core_rst_n, run_en, busy, done, halted, timed_out;
  logic [CNT_W-1:0] cycle_count;
  logic [PC_W-1:0]  last_pc;

  always #5 clk = ~clk;

  run_control_unit #(
    .CNT_W   (CNT_W),
    .PC_W    (PC_W),
    .RST_HOLD(RST_HOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .halt          (halt),
    .timeout_cycles(timeout_cycles),
    .core_pc       (core_pc),
    .core_rst_n    (core_rst_n),
    .run_en        (run_en),
    .busy          (busy),
    .done          (done),
    .halted        (halted),
    .timed_out     (timed_out),
    .cycle_count   (cycle_count),
    .last_pc       (last_pc)
  );

  typedef struct {
    bit              done;
    bit              halted;
    bit              timed_out;
    int unsigned     cnt;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t            sb[$];
  int unsigned     n_cmp = 0;
  int unsigned     n_err = 0;
  logic [PC_W-1:0] model_pc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: reset-hold length, done pulse width, and run outcome on busy falling.
  bit          busy_p = 1'b0;
  bit          done_p = 1'b0;
  int unsigned hold_n = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_p = 1'b0;
        done_p = 1'b0;
        hold_n = 0;
      end else begin
        if (done_p) check("done_one_cycle", 64'(done), 64'd0);
        if (busy && !core_rst_n) begin
          hold_n++;
          check("reset_run_en", 64'(run_en), 64'd0);
        end else if (busy && core_rst_n && hold_n != 0) begin
          check("rst_hold_len", 64'(hold_n), 64'(RST_HOLD));
          check("run_en_on", 64'(run_en), 64'd1);
          hold_n = 0;
        end
        if (busy_p && !busy) begin
          hold_n = 0;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: run ended with no expected outcome queued");
          end else begin
            e = sb.pop_front();
            check("done", 64'(done), 64'(e.done));
            check("halted", 64'(halted), 64'(e.halted));
            check("timed_out", 64'(timed_out), 64'(e.timed_out));
            check("cycle_count", 64'(cycle_count), 64'(e.cnt));
            check("last_pc", 64'(last_pc), 64'(e.pc));
            check("core_rst_n_end", 64'(core_rst_n), 64'(e.done));
            check("run_en_end", 64'(run_en), 64'd0);
          end
        end
        busy_p = busy;
        done_p = done;
      end
    end
  end

  // One run: t = timeout, h = RUN edge carrying halt, ar = RESET edge carrying
  // abort, arun = RUN edge carrying abort (0 = none for h/ar/arun).
  task automatic run_one(input int unsigned t, input int unsigned h, input int unsigned ar,
                         input int unsigned arun, input bit spur, input bit use_pcf,
                         input logic [PC_W-1:0] pcf);
    exp_t            e;
    int unsigned     eh, et, ea, last;
    logic [PC_W-1:0] end_pc;
    eh     = (h != 0) ? h : NEVER;
    et     = (t != 0) ? t : NEVER;
    ea     = (arun != 0) ? arun : NEVER;
    end_pc = use_pcf ? pcf : PC_W'($urandom);
    e.done = 1'b0; e.halted = 1'b0; e.timed_out = 1'b0; e.cnt = 0; e.pc = model_pc;
    last   = 0;
    if (ar == 0) begin
      if (ea <= eh && ea <= et) begin
        last  = ea;
        e.cnt = ea - 1;
      end else begin
        e.done   = 1'b1;
        e.pc     = end_pc;
        model_pc = end_pc;
        if (eh <= et) begin
          last = eh; e.halted = 1'b1; e.cnt = eh;
        end else begin
          last = et; e.timed_out = 1'b1; e.cnt = et;
        end
      end
    end
    sb.push_back(e);

    @(negedge clk);
    start = 1'b1; abort = 1'b0; halt = 1'b0; timeout_cycles = CNT_W'(t);
    for (int unsigned j = 1; j <= RST_HOLD; j++) begin
      @(negedge clk);
      start          = spur && ($urandom_range(0, 1) == 1);
      abort          = (ar == j);
      core_pc        = PC_W'($urandom);
      timeout_cycles = CNT_W'($urandom);
      if (ar == j) break;
    end
    if (ar == 0) begin
      for (int unsigned i = 1; i <= last; i++) begin
        @(negedge clk);
        start          = spur && ($urandom_range(0, 1) == 1);
        abort          = (arun == i);
        halt           = (h == i);
        core_pc        = (i == last) ? end_pc : PC_W'($urandom);
        timeout_cycles = CNT_W'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; halt = 1'b0;
  endtask

  initial begin
    int unsigned t, h, ar, arun;

    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_core_rst_n", 64'(core_rst_n), 64'd0);
    check("idle_run_en", 64'(run_en), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_halted", 64'(halted), 64'd0);
    check("idle_timed_out", 64'(timed_out), 64'd0);
    check("idle_cycle_count", 64'(cycle_count), 64'd0);
    check("idle_last_pc", 64'(last_pc), 64'd0);

    run_one(100, 7, 0, 0, 1'b0, 1'b1, 16'h001C);
    run_one(10, 0, 0, 0, 1'b0, 1'b0, '0);
    run_one(0, 3, 0, 0, 1'b0, 1'b0, '0);
    run_one(5, 5, 0, 0, 1'b0, 1'b0, '0);
    run_one(20, 0, 2, 0, 1'b1, 1'b0, '0);
    run_one(20, 4, 0, 4, 1'b1, 1'b0, '0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; timeout_cycles = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (RST_HOLD + 5) @(negedge clk);
    check("pre_rst_run_en", 64'(run_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_core_rst_n", 64'(core_rst_n), 64'd0);
    check("async_run_en", 64'(run_en), 64'd0);
    check("async_cycle_count", 64'(cycle_count), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    model_pc = '0;
    repeat (2) @(negedge clk);
    check("post_rst_done", 64'(done), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    for (int unsigned r = 0; r < 40; r++) begin
      t    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      h    = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 25);
      ar   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, RST_HOLD) : 0;
      arun = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 25) : 0;
      if (t == 0 && h == 0 && arun == 0) h = $urandom_range(1, 25);
      run_one(t, h, ar, arun, ($urandom_range(0, 1) == 1), 1'b0, '0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
